dot_product_seq: RTL and testbench

- Sequential dot-product controller. It sits directly upstream of the combinational MAC (Y = A*B + C) and consumes the MAC's Y.
- Accepts a stream of operand pairs and drives them onto MAC A/B. Its own accumulator register drives MAC C, and MAC Y is registered back into that accumulator.
- After LEN pairs it presents the final sum on a valid/ready output port.

---
 rtl/dot_seq_pkg.sv | 12 +
 rtl/dot_product_seq.sv | 148 ++++++++++++++
 tb/tb_dot_product_seq.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/dot_seq_pkg.sv
// Shared types and helpers for the sequential dot-product controller.
package dot_seq_pkg;

   // Two-phase controller: accumulate beats, then hold the result for downstream.
   typedef enum logic {S_ACC = 1'b0, S_OUT = 1'b1} dot_state_e;

   // Accumulator width equals the MAC output width (full product width).
   function automatic int acc_width(input int wa, input int wb);
      return wa + wb;
   endfunction

endpackage

// File: rtl/dot_product_seq.sv
// Sequential dot-product controller sitting upstream of a combinational MAC
// (Y = A*B + C). Operands pass straight to MAC A/B, the accumulator drives
// MAC C, and MAC Y is captured back into the accumulator on every beat.
// After LEN beats the sum is offered on a valid/ready output port.
// Optional: define DOT_OVF_DETECT_EN to add the out_ovf wrap indicator.
module dot_product_seq
   import dot_seq_pkg::*;
#(
   parameter int WIDTH_A = 5,
   parameter int WIDTH_B = 7,
   parameter int LEN     = 4
) (
   input  logic                                   clk,
   input  logic                                   rst_n,
   input  logic                                   clr,
   input  logic                                   in_valid,
   output logic                                   in_ready,
   input  logic [WIDTH_A-1:0]                     in_a,
   input  logic [WIDTH_B-1:0]                     in_b,
   output logic [WIDTH_A-1:0]                     mac_a,
   output logic [WIDTH_B-1:0]                     mac_b,
   output logic [acc_width(WIDTH_A, WIDTH_B)-1:0] mac_c,
   input  logic [acc_width(WIDTH_A, WIDTH_B)-1:0] mac_y,
   output logic                                   out_valid,
   input  logic                                   out_ready,
   output logic [acc_width(WIDTH_A, WIDTH_B)-1:0] out_sum
`ifdef DOT_OVF_DETECT_EN
   ,
   output logic                                   out_ovf
`endif
);

   localparam int ACC_W = acc_width(WIDTH_A, WIDTH_B);
   localparam int CNT_W = (LEN > 1) ? $clog2(LEN) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);

   dot_state_e        state_r, state_s;
   logic [ACC_W-1:0]  acc_r, acc_s;
   logic [CNT_W-1:0]  cnt_r, cnt_s;
   logic [ACC_W-1:0]  sum_s;
   logic              rdy_en_r;
   logic              beat_s;
   logic              wrap_s;
`ifdef DOT_OVF_DETECT_EN
   logic              ovf_acc_r, ovf_acc_s;
   logic              out_ovf_s;
`endif

   assign mac_a = in_a;
   assign mac_b = in_b;
   assign mac_c = acc_r;

   // rdy_en_r keeps in_ready low while reset is held; it rises on the first edge after release.
   assign in_ready  = (state_r == S_ACC) && rdy_en_r;
   assign out_valid = (state_r == S_OUT);
   assign beat_s    = in_valid && in_ready;
   // Y = A*B + C with A*B < 2^ACC_W, so Y < C means exactly one wrap occurred.
   assign wrap_s    = (mac_y < acc_r);

   // Next-state and datapath update for the accumulate/output FSM.
   always_comb begin
      state_s = state_r;
      acc_s   = acc_r;
      cnt_s   = cnt_r;
      sum_s   = out_sum;
`ifdef DOT_OVF_DETECT_EN
      ovf_acc_s = ovf_acc_r;
      out_ovf_s = out_ovf;
`endif
      case (state_r)
         S_ACC: begin
            if (clr) begin
               // Abort wins over a simultaneous beat.
               acc_s = {ACC_W{1'b0}};
               cnt_s = {CNT_W{1'b0}};
`ifdef DOT_OVF_DETECT_EN
               ovf_acc_s = 1'b0;
`endif
            end else if (beat_s) begin
               if (cnt_r == CNT_LAST) begin
                  sum_s   = mac_y;
                  acc_s   = {ACC_W{1'b0}};
                  cnt_s   = {CNT_W{1'b0}};
                  state_s = S_OUT;
`ifdef DOT_OVF_DETECT_EN
                  out_ovf_s = ovf_acc_r | wrap_s;
                  ovf_acc_s = 1'b0;
`endif
               end else begin
                  acc_s = mac_y;
                  cnt_s = cnt_r + CNT_W'(1);
`ifdef DOT_OVF_DETECT_EN
                  ovf_acc_s = ovf_acc_r | wrap_s;
`endif
               end
            end else begin
               state_s = S_ACC;
            end
         end
         S_OUT: begin
            // clr and in_valid are ignored here; the result must drain first.
            if (out_ready) begin
               state_s = S_ACC;
            end else begin
               state_s = S_OUT;
            end
         end
         default: begin
            state_s = S_ACC;
            acc_s   = {ACC_W{1'b0}};
            cnt_s   = {CNT_W{1'b0}};
         end
      endcase
   end

   // FSM state, accumulator, beat counter and result registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= S_ACC;
         acc_r   <= {ACC_W{1'b0}};
         cnt_r   <= {CNT_W{1'b0}};
         out_sum <= {ACC_W{1'b0}};
`ifdef DOT_OVF_DETECT_EN
         ovf_acc_r <= 1'b0;
         out_ovf   <= 1'b0;
`endif
      end else begin
         state_r <= state_s;
         acc_r   <= acc_s;
         cnt_r   <= cnt_s;
         out_sum <= sum_s;
`ifdef DOT_OVF_DETECT_EN
         ovf_acc_r <= ovf_acc_s;
         out_ovf   <= out_ovf_s;
`endif
      end
   end

   // Input-ready enable: low in reset, set on the first clock after release.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdy_en_r <= 1'b0;
      end else begin
         rdy_en_r <= 1'b1;
      end
   end

endmodule

// File: tb/tb_dot_product_seq.sv
// Directed self-checking bench for dot_product_seq with a behavioural MAC.
// Instantiates a LEN=4 and a LEN=1 controller. Out_ovf is checked when
// DOT_OVF_DETECT_EN is defined.
module tb_dot_product_seq;

   logic clk;
   logic rst_n;

   // LEN=4 instance signals
   logic        clr, in_valid, in_ready, out_valid, out_ready;
   logic [4:0]  in_a, mac_a;
   logic [6:0]  in_b, mac_b;
   logic [11:0] mac_c, mac_y, out_sum;
`ifdef DOT_OVF_DETECT_EN
   logic        out_ovf;
`endif

   // LEN=1 instance signals
   logic        clr1, in_valid1, in_ready1, out_valid1, out_ready1;
   logic [4:0]  in_a1, mac_a1;
   logic [6:0]  in_b1, mac_b1;
   logic [11:0] mac_c1, mac_y1, out_sum1;
`ifdef DOT_OVF_DETECT_EN
   logic        out_ovf1;
`endif

   int passed = 0;
   int total  = 0;

   // Behavioural MACs: Y = A*B + C modulo 2^12
   assign mac_y  = {7'd0, mac_a}  * {5'd0, mac_b}  + mac_c;
   assign mac_y1 = {7'd0, mac_a1} * {5'd0, mac_b1} + mac_c1;

   dot_product_seq #(.WIDTH_A(5), .WIDTH_B(7), .LEN(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr),
      .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
      .mac_a(mac_a), .mac_b(mac_b), .mac_c(mac_c), .mac_y(mac_y),
      .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum)
`ifdef DOT_OVF_DETECT_EN
      , .out_ovf(out_ovf)
`endif
   );

   dot_product_seq #(.WIDTH_A(5), .WIDTH_B(7), .LEN(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .clr(clr1),
      .in_valid(in_valid1), .in_ready(in_ready1), .in_a(in_a1), .in_b(in_b1),
      .mac_a(mac_a1), .mac_b(mac_b1), .mac_c(mac_c1), .mac_y(mac_y1),
      .out_valid(out_valid1), .out_ready(out_ready1), .out_sum(out_sum1)
`ifdef DOT_OVF_DETECT_EN
      , .out_ovf(out_ovf1)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
   endtask

   // Advance one clock; inputs/outputs settle 1 time unit after the edge.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic beat(input logic [4:0] a, input logic [6:0] b);
      in_valid = 1'b1;
      in_a     = a;
      in_b     = b;
      step();
      in_valid = 1'b0;
   endtask

   // Test-1 vector, 4 back-to-back beats; result 615.
   task automatic vec1();
      beat(5'd13, 7'd23);
      beat(5'd15, 7'd21);
      beat(5'd1,  7'd1);
      beat(5'd0,  7'd127);
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; in_valid = 1'b0; in_a = 5'd0; in_b = 7'd0; out_ready = 1'b1;
      clr1 = 1'b0; in_valid1 = 1'b0; in_a1 = 5'd0; in_b1 = 7'd0; out_ready1 = 1'b1;
      #12;
      // Reset state
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_out_sum",   32'(out_sum),   32'd0);
      chk("rst_in_ready",  32'(in_ready),  32'd0);
      #10 rst_n = 1'b1;
      step();
      chk("post_rst_in_ready", 32'(in_ready), 32'd1);

      // Test 1: back-to-back vector, out_ready=1
      in_a = 5'd9; in_b = 7'd3; #1;
      chk("mac_a_pass", 32'(mac_a), 32'd9);
      chk("mac_b_pass", 32'(mac_b), 32'd3);
      vec1();
      chk("t1_out_valid", 32'(out_valid), 32'd1);
      chk("t1_out_sum",   32'(out_sum),   32'd615);
      chk("t1_in_ready0", 32'(in_ready),  32'd0);
      step();
      chk("t1_out_valid_drop", 32'(out_valid), 32'd0);
      chk("t1_in_ready1",      32'(in_ready),  32'd1);

      // Test 2: back-pressure for 3 cycles; clr and in_valid ignored in S_OUT
      out_ready = 1'b0;
      vec1();
      chk("t2_out_sum_0", 32'(out_sum), 32'd615);
      in_valid = 1'b1; in_a = 5'd31; in_b = 7'd127; clr = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("t2_hold_valid", 32'(out_valid), 32'd1);
         chk("t2_hold_sum",   32'(out_sum),   32'd615);
         chk("t2_hold_ready", 32'(in_ready),  32'd0);
      end
      in_valid = 1'b0; clr = 1'b0; out_ready = 1'b1;
      step();
      chk("t2_back_acc_valid", 32'(out_valid), 32'd0);
      chk("t2_back_acc_ready", 32'(in_ready),  32'd1);
      // Nothing leaked in: a fresh vector still sums to 615
      vec1();
      chk("t2_next_sum", 32'(out_sum), 32'd615);
      step();

      // Test 3: overflow vector 2*3937 = 7874 -> 3778 mod 4096
      beat(5'd31, 7'd127);
      beat(5'd31, 7'd127);
      beat(5'd0,  7'd0);
      beat(5'd0,  7'd0);
      chk("t3_out_sum", 32'(out_sum), 32'd3778);
`ifdef DOT_OVF_DETECT_EN
      chk("t3_out_ovf1", 32'(out_ovf), 32'd1);
`endif
      step();
      vec1();
      chk("t3_next_sum", 32'(out_sum), 32'd615);
`ifdef DOT_OVF_DETECT_EN
      chk("t3_out_ovf0", 32'(out_ovf), 32'd0);
`endif
      step();

      // Test 4: clr after 2 beats (with a colliding beat), then 4 x (2,3) = 24
      beat(5'd5, 7'd5);
      beat(5'd5, 7'd5);
      clr = 1'b1;
      beat(5'd5, 7'd5);
      clr = 1'b0;
      chk("t4_clr_no_out", 32'(out_valid), 32'd0);
      for (int i = 0; i < 4; i++) beat(5'd2, 7'd3);
      chk("t4_out_valid", 32'(out_valid), 32'd1);
      chk("t4_out_sum",   32'(out_sum),   32'd24);
      step();

      // Test 5: reset after 3 beats, then a full vector
      beat(5'd13, 7'd23);
      beat(5'd15, 7'd21);
      beat(5'd1,  7'd1);
      #2 rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", 32'(out_valid), 32'd0);
      chk("t5_rst_sum",   32'(out_sum),   32'd0);
      step();
      chk("t5_rst_valid_hold", 32'(out_valid), 32'd0);
      #2 rst_n = 1'b1;
      step();
      vec1();
      chk("t5_out_valid", 32'(out_valid), 32'd1);
      chk("t5_out_sum",   32'(out_sum),   32'd615);
      step();

      // Test 6: LEN=1 instance
      in_valid1 = 1'b1; in_a1 = 5'd13; in_b1 = 7'd23;
      step();
      in_valid1 = 1'b0;
      chk("t6_valid_a", 32'(out_valid1), 32'd1);
      chk("t6_sum_a",   32'(out_sum1),   32'd299);
      step();
      chk("t6_idle", 32'(out_valid1), 32'd0);
      in_valid1 = 1'b1; in_a1 = 5'd15; in_b1 = 7'd21;
      step();
      in_valid1 = 1'b0;
      chk("t6_valid_b", 32'(out_valid1), 32'd1);
      chk("t6_sum_b",   32'(out_sum1),   32'd315);
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
